gray_code_counter: RTL and testbench

- Parametrised, registered up/down counter that presents its count in binary and reflected Gray code at the same time.
- Successor to the team's fixed 4-bit combinational binary-to-Gray encoder. Adds:
  - generic width
  - count direction
  - parallel load in either code
  - wrap or saturate mode
  - wrap/terminal flags
- Intended for FIFO pointer generation and rotary/position interfaces, where exactly one Gray bit may change per step.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_to_binary_decoder.sv | 13 +
 rtl/gray_code_counter.sv | 80 ++++++++
 tb/tb_gray_code_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and its load-path decoder.
// Functions work on a wide container; zero-extend narrower values in and truncate results out.
package gray_pkg;

  localparam int GRAY_MAX_W = 64;

  // Terminal patterns; slice or cast down to the counter width at the point of use.
  localparam logic [GRAY_MAX_W-1:0] ALL_ONES = '1;
  localparam logic [GRAY_MAX_W-1:0] ZERO     = '0;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits leave the prefix XOR unaffected, so any width up to GRAY_MAX_W works.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary_decoder.sv
// Combinational reflected-Gray to binary converter, used on the counter's load path.
module gray_to_binary_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(gray2bin(GRAY_MAX_W'(gray_i)));

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down counter presenting binary and Gray code together, with
// parallel load in either code, wrap or saturate at terminal, and wrap/sat flags.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter bit              WRAP_EN = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             sat
);

  localparam logic [WIDTH-1:0] ONES     = WIDTH'(ALL_ONES);
  localparam logic [WIDTH-1:0] ZEROS    = WIDTH'(ZERO);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] load_bin;

  gray_to_binary_decoder #(.WIDTH(WIDTH)) u_load_dec (
    .gray_i (load_val),
    .bin_o  (load_bin)
  );

  assign tc = up_dn ? (bin_q == ONES) : (bin_q == ZEROS);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (load) begin
      bin_d = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      if (!tc) begin
        bin_d = up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      end else if (WRAP_EN) begin
        bin_d  = up_dn ? ZEROS : ONES;
        wrap_d = 1'b1;
      end else begin
        sat_d  = 1'b1;
      end
    end
    // Gray register is fed from the next binary value, never decoded from bin_q.
    gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RST_VAL;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_out    = bin_q;
  assign gray_out   = gray_q;
  assign wrap_pulse = wrap_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Three counter instances (4-bit wrap, 4-bit saturate with RST_VAL=3, 8-bit wrap)
// share one stimulus stream and are compared every cycle against an arithmetic model.
module tb_gray_code_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up_dn, load, load_is_gray;
  logic [7:0] load_val;

  logic [3:0] b0, g0, b1, g1;
  logic [7:0] b2, g2;
  logic       tc0, wp0, st0, tc1, wp1, st1, tc2, wp2, st2;

  gray_code_counter #(.WIDTH(4), .WRAP_EN(1'b1), .RST_VAL(4'd0)) u_w4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val[3:0]), .bin_out(b0), .gray_out(g0), .tc(tc0), .wrap_pulse(wp0), .sat(st0));

  gray_code_counter #(.WIDTH(4), .WRAP_EN(1'b0), .RST_VAL(4'd3)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val[3:0]), .bin_out(b1), .gray_out(g1), .tc(tc1), .wrap_pulse(wp1), .sat(st1));

  gray_code_counter #(.WIDTH(8), .WRAP_EN(1'b1), .RST_VAL(8'd0)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val), .bin_out(b2), .gray_out(g2), .tc(tc2), .wrap_pulse(wp2), .sat(st2));

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: plain integers per instance.
  int mw[3]  = '{4, 4, 8};
  bit men[3] = '{1'b1, 1'b0, 1'b1};
  int mrv[3] = '{0, 3, 0};
  int mb[3];
  bit mwp[3], mst[3], mstp[3];
  logic [7:0] pg[3];

  // Decode by search: the binary value whose Gray image equals g.
  function automatic int gray_dec(input int g, input int w);
    for (int b = 0; b < (1 << w); b++)
      if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int mx;
      mx = (1 << mw[k]) - 1;
      mstp[k] = 1'b0;
      if (rst) begin
        mb[k] = mrv[k]; mwp[k] = 0; mst[k] = 0;
      end else if (load) begin
        mb[k] = load_is_gray ? gray_dec(int'(load_val) & mx, mw[k]) : (int'(load_val) & mx);
        mwp[k] = 0; mst[k] = 0;
      end else if (en) begin
        int nxt;
        nxt = up_dn ? mb[k] + 1 : mb[k] - 1;
        if (nxt >= 0 && nxt <= mx) begin
          mb[k] = nxt; mwp[k] = 0; mst[k] = 0; mstp[k] = 1;
        end else if (men[k]) begin
          mb[k] = nxt & mx; mwp[k] = 1; mst[k] = 0; mstp[k] = 1;
        end else begin
          mwp[k] = 0; mst[k] = 1;
        end
      end else begin
        mwp[k] = 0; mst[k] = 0;
      end
    end
  end

  logic [7:0] ab[3], ag[3];
  logic       atc[3], awp[3], ast[3];
  assign ab[0] = {4'b0, b0}; assign ag[0] = {4'b0, g0};
  assign ab[1] = {4'b0, b1}; assign ag[1] = {4'b0, g1};
  assign ab[2] = b2;         assign ag[2] = g2;
  assign atc[0] = tc0; assign awp[0] = wp0; assign ast[0] = st0;
  assign atc[1] = tc1; assign awp[1] = wp1; assign ast[1] = st1;
  assign atc[2] = tc2; assign awp[2] = wp2; assign ast[2] = st2;

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        int mx;
        mx = (1 << mw[k]) - 1;
        chk($sformatf("bin[%0d]", k), 32'(ab[k]), mb[k]);
        chk($sformatf("gray[%0d]", k), 32'(ag[k]), mb[k] ^ (mb[k] >> 1));
        chk($sformatf("tc[%0d]", k), 32'(atc[k]), up_dn ? 32'(mb[k] == mx) : 32'(mb[k] == 0));
        chk($sformatf("wrap_pulse[%0d]", k), 32'(awp[k]), 32'(mwp[k]));
        chk($sformatf("sat[%0d]", k), 32'(ast[k]), 32'(mst[k]));
        if (mstp[k]) chk($sformatf("gray_onebit[%0d]", k), $countones(ag[k] ^ pg[k]), 1);
        pg[k] = ag[k];
      end
    end
  end

  task automatic drive(input bit r, input bit e, input bit u, input bit l, input bit lg, input logic [7:0] v);
    rst = r; en = e; up_dn = u; load = l; load_is_gray = lg; load_val = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit seen[256];
  int wraps, distinct;

  initial begin
    drive(1, 0, 1, 0, 0, 8'd0);
    tick(); tick();
    started = 1'b1;
    chk("rst_bin4", 32'(b0), 0);
    chk("rst_gray4", 32'(g0), 0);
    chk("rst_wrap4", 32'(wp0), 0);
    chk("rst_bin_sat", 32'(b1), 3);
    chk("rst_gray_sat", 32'(g1), 2);

    // Up-count through a full 4-bit cycle.
    drive(0, 1, 1, 0, 0, 8'd0);
    repeat (3) tick();
    chk("up3_gray4", 32'(g0), 32'b0010);
    repeat (12) tick();
    chk("up15_bin4", 32'(b0), 15);
    chk("up15_gray4", 32'(g0), 32'b1000);
    chk("up15_tc4", 32'(tc0), 1);
    tick();
    chk("wrap_up_bin4", 32'(b0), 0);
    chk("wrap_up_pulse4", 32'(wp0), 1);

    // Down from zero wraps to all-ones.
    drive(0, 1, 0, 0, 0, 8'd0);
    tick();
    chk("wrap_dn_bin4", 32'(b0), 15);
    chk("wrap_dn_gray4", 32'(g0), 32'b1000);
    chk("wrap_dn_pulse4", 32'(wp0), 1);
    tick();
    chk("dn14_bin4", 32'(b0), 14);
    chk("dn14_pulse4", 32'(wp0), 0);

    // Saturate instance: load 14, count up into terminal and hold.
    drive(0, 1, 1, 1, 0, 8'd14);
    tick();
    chk("sat_load_bin", 32'(b1), 14);
    drive(0, 1, 1, 0, 0, 8'd0);
    tick();
    chk("sat_15_bin", 32'(b1), 15);
    chk("sat_15_tc", 32'(tc1), 1);
    chk("sat_15_sat", 32'(st1), 0);
    tick();
    chk("sat_hold_bin", 32'(b1), 15);
    chk("sat_hold_sat", 32'(st1), 1);
    chk("sat_hold_wrap", 32'(wp1), 0);
    drive(0, 1, 0, 0, 0, 8'd0);
    tick();
    chk("sat_release_bin", 32'(b1), 14);
    chk("sat_release_sat", 32'(st1), 0);

    // Gray load with enable: load wins, no step.
    drive(0, 1, 1, 1, 1, 8'h0D);
    tick();
    chk("gload_bin4", 32'(b0), 32'b1001);
    chk("gload_gray4", 32'(g0), 32'b1101);

    // Reset mid-count beats a simultaneous load.
    drive(0, 0, 1, 1, 0, 8'd7);
    tick();
    chk("pre_rst_bin4", 32'(b0), 7);
    drive(1, 1, 1, 1, 0, 8'd3);
    tick();
    chk("midrst_bin4", 32'(b0), 0);
    chk("midrst_wrap4", 32'(wp0), 0);
    chk("midrst_sat4", 32'(st0), 0);
    chk("midrst_bin_sat", 32'(b1), 3);

    // 8-bit full cycle.
    drive(0, 1, 1, 0, 0, 8'd0);
    wraps = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    repeat (256) begin
      tick();
      seen[g2] = 1'b1;
      if (wp2) wraps++;
    end
    distinct = 0;
    foreach (seen[i]) if (seen[i]) distinct++;
    chk("w8_distinct_gray", distinct, 256);
    chk("w8_wraps", wraps, 1);
    chk("w8_back_to_zero", 32'(b2), 0);

    // Randomized traffic.
    repeat (400) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      tick();
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
